// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: BFT packet layout, transmitter states and packet build/credit-match helpers
package leaf_pkt_pkg;
    localparam logic [3:0] CTRL_PORT = 4'd0;

    typedef enum logic [1:0] {S_RUN, S_NOCRED, S_HOLD} state_t;

    // [48]=valid [47:43]=leaf [42:39]=port [38:32]=seq [31:0]=payload
    function automatic logic [48:0] build_pkt(input logic [4:0] leaf, input logic [3:0] port,
                                              input logic [6:0] seq, input logic [31:0] data);
        return {1'b1, leaf, port, seq, data};
    endfunction

    function automatic logic credit_match(input logic valid, input logic [4:0] leaf,
                                          input logic [3:0] port, input logic [3:0] tag,
                                          input logic [4:0] my_leaf, input logic [3:0] my_port);
        return valid && leaf == my_leaf && port == CTRL_PORT && tag == my_port;
    endfunction
endpackage

// File: rtl/leaf_credit_counter.sv
// leaf_credit_counter: credit register, one consumed per packet, returns added, saturating at MAX.
module leaf_credit_counter #(
    parameter int W   = 8,
    parameter int MAX = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_consume,
    input  logic [7:0]   i_return,
    output logic [W-1:0] o_count
);
    logic [W+1:0] w_sum;
    logic [W-1:0] w_next;

    // consume only happens while count > 0, so the sum never underflows
    always_comb begin
        w_sum  = (W+2)'(o_count) - (W+2)'(i_consume) + (W+2)'(i_return);
        w_next = w_sum > (W+2)'(MAX) ? W'(MAX) : w_sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) o_count <= W'(MAX);
        else     o_count <= w_next;
endmodule

// File: rtl/leaf_stream_tx.sv
// leaf_stream_tx: packs user words into BFT packets under credit flow control.
// Optional LEAF_TX_SEQ_EN: carries a wrapping sequence number in [38:32] (tied to 0 otherwise).
module leaf_stream_tx
    import leaf_pkt_pkg::*;
#(
    parameter int         PACKET_BITS        = 49,
    parameter int         PAYLOAD_BITS       = 32,
    parameter int         NUM_LEAF_BITS      = 5,
    parameter int         NUM_PORT_BITS      = 4,
    parameter int         NUM_ADDR_BITS      = 7,
    parameter int         NUM_BRAM_ADDR_BITS = 7,
    parameter logic [4:0] MY_LEAF            = 5'd0,
    parameter logic [3:0] MY_PORT            = 4'd1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LEAF_BITS-1:0]    dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]    dest_port,
    input  logic [PAYLOAD_BITS-1:0]     din_user,
    input  logic                        vld_user,
    output logic                        ack_user,
    input  logic [PACKET_BITS-1:0]      din_bft,
    output logic [PACKET_BITS-1:0]      dout_bft,
    input  logic                        resend,
    output logic [NUM_BRAM_ADDR_BITS:0] credit
);
    state_t                   w_state;
    logic                     r_live;
    logic                     w_xfer;
    logic [7:0]               w_ret;
    logic [NUM_ADDR_BITS-1:0] w_seq;
    logic [PACKET_BITS-1:0]   r_pkt;
    logic                     w_unused;

    assign w_unused = ^{din_bft[38:32], din_bft[27:8]};

    // ack stays low while reset is asserted and until the first edge after release
    always_ff @(posedge clk or posedge reset)
        if (reset) r_live <= 1'b0;
        else       r_live <= 1'b1;

    always_comb begin
        w_state  = resend ? S_HOLD : (credit == '0 ? S_NOCRED : S_RUN);
        ack_user = r_live && w_state == S_RUN;
        w_xfer   = vld_user && ack_user;
        w_ret    = credit_match(din_bft[48], din_bft[47:43], din_bft[42:39], din_bft[31:28],
                                MY_LEAF, MY_PORT) ? din_bft[7:0] : 8'd0;
    end

    leaf_credit_counter #(
        .W   (NUM_BRAM_ADDR_BITS + 1),
        .MAX (2 ** NUM_BRAM_ADDR_BITS)
    ) u_credit (
        .clk       (clk),
        .rst       (reset),
        .i_consume (w_xfer),
        .i_return  (w_ret),
        .o_count   (credit)
    );

`ifdef LEAF_TX_SEQ_EN
    logic [NUM_ADDR_BITS-1:0] r_seq;
    always_ff @(posedge clk or posedge reset)
        if (reset)       r_seq <= '0;
        else if (w_xfer) r_seq <= r_seq + 1'b1;
    assign w_seq = r_seq;
`else
    assign w_seq = '0;
`endif

    // a packet caught by resend stays in the register until resend drops
    always_ff @(posedge clk or posedge reset)
        if (reset)        r_pkt <= '0;
        else if (w_xfer)  r_pkt <= build_pkt(dest_leaf, dest_port, w_seq, din_user);
        else if (!resend) r_pkt <= '0;

    assign dout_bft = resend ? '0 : r_pkt;
endmodule

// File: tb/tb_leaf_stream_tx.sv
// tb_leaf_stream_tx: directed and random stimulus for leaf_stream_tx against a packet-queue/credit model.
module tb_leaf_stream_tx;
    localparam logic [4:0] ML = 5'd0;
    localparam logic [3:0] MP = 4'd1;
`ifdef LEAF_TX_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  dest_leaf = '0;
    logic [3:0]  dest_port = 4'd1;
    logic [31:0] din_user = '0;
    logic        vld_user = 1'b0;
    logic        ack_user;
    logic [48:0] din_bft = '0;
    logic [48:0] dout_bft;
    logic        resend = 1'b0;
    logic [7:0]  credit;

    always #5 clk = ~clk;

    leaf_stream_tx #(.MY_LEAF(ML), .MY_PORT(MP)) dut (
        .clk(clk), .reset(reset), .dest_leaf(dest_leaf), .dest_port(dest_port),
        .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
        .din_bft(din_bft), .dout_bft(dout_bft), .resend(resend), .credit(credit)
    );

    int n_pass = 0, n_chk = 0;
    int cred = 128, seq = 0, n_dut_acc = 0;
    logic [48:0] pend[$];
    logic [4:0]  leaf = '0;
    logic [3:0]  port = 4'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [48:0] cpkt(input logic [4:0] lf, input logic [3:0] pt,
                                         input logic [3:0] tag, input logic [7:0] cnt);
        return {1'b1, lf, pt, 7'd0, tag, 20'd0, cnt};
    endfunction

    // one cycle: drive, check against the model, advance the model across the edge
    task automatic step(input logic v, input logic [31:0] d, input logic rs, input logic [48:0] bp);
        logic [48:0] exp_d;
        logic        exp_ack;
        int          cnt;
        vld_user = v; din_user = d; resend = rs; din_bft = bp;
        dest_leaf = leaf; dest_port = port;
        #1;
        exp_ack = !rs && cred > 0;
        exp_d   = (!rs && pend.size() > 0) ? pend[0] : '0;
        chk("ack", 64'(ack_user), 64'(exp_ack));
        chk("dout", 64'(dout_bft), 64'(exp_d));
        chk("credit", 64'(credit), 64'(cred));
        if (ack_user && v) n_dut_acc++;
        if (!rs && pend.size() > 0) void'(pend.pop_front());
        if (v && exp_ack) begin
            pend.push_back({1'b1, leaf, port, 7'(seq), d});
            seq = SEQ_EN ? (seq + 1) % 128 : 0;
        end
        cnt = (bp[48] && bp[47:43] == ML && bp[42:39] == 4'd0 && bp[31:28] == MP) ? int'(bp[7:0]) : 0;
        cred = cred - int'(v && exp_ack) + cnt;
        if (cred > 128) cred = 128;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        vld_user = 1'b0; resend = 1'b0; din_bft = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_dout", 64'(dout_bft), 64'd0);
        chk("rst_ack", 64'(ack_user), 64'd0);
        chk("rst_credit", 64'(credit), 64'd128);
        reset = 1'b0;
        cred = 128; seq = 0; pend.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [48:0] bp;
        logic [31:0] w;
        // reset and release
        @(negedge clk);
        reset_dut();
        chk("t1_ack", 64'(ack_user), 64'd1);
        chk("t1_credit", 64'(credit), 64'd128);
        // single word DEADBEEF to leaf 3 port 2
        leaf = 5'd3; port = 4'd2;
        step(1'b1, 32'hDEADBEEF, 1'b0, '0);
        chk("t2_pkt", 64'(dout_bft), 64'h1_1900_DEAD_BEEF);
        step(1'b0, '0, 1'b0, '0);
        chk("t2_idle", 64'(dout_bft), 64'd0);
        step(1'b0, '0, 1'b0, '0);
        // 128 back-to-back words drain the credit
        reset_dut();
        leaf = 5'd9; port = 4'd5;
        for (int i = 0; i < 128; i++) step(1'b1, $urandom, 1'b0, '0);
        chk("t3_ack0", 64'(ack_user), 64'd0);
        chk("t3_cred0", 64'(credit), 64'd0);
        chk("t3_lastseq", 64'(dout_bft[38:32]), SEQ_EN ? 64'd127 : 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, '0);
        // credit return of 64 at zero credit
        step(1'b0, '0, 1'b0, cpkt(ML, 4'd0, MP, 8'd64));
        chk("t4_ack", 64'(ack_user), 64'd1);
        n_dut_acc = 0;
        for (int i = 0; i < 70; i++) step(1'b1, $urandom, 1'b0, '0);
        chk("t4_count", 64'(n_dut_acc), 64'd64);
        // credit 1, transfer and return of 64 on the same edge
        step(1'b0, '0, 1'b0, cpkt(ML, 4'd0, MP, 8'd1));
        step(1'b1, 32'h1234_5678, 1'b0, cpkt(ML, 4'd0, MP, 8'd64));
        chk("t5_credit", 64'(credit), 64'd64);
        chk("t5_ack", 64'(ack_user), 64'd1);
        // non-matching returns ignored, saturation at 128
        step(1'b0, '0, 1'b0, cpkt(ML + 5'd1, 4'd0, MP, 8'd10));
        step(1'b0, '0, 1'b0, cpkt(ML, 4'd3, MP, 8'd10));
        step(1'b0, '0, 1'b0, cpkt(ML, 4'd0, MP + 4'd1, 8'd10));
        bp = cpkt(ML, 4'd0, MP, 8'd10); bp[48] = 1'b0;
        step(1'b0, '0, 1'b0, bp);
        chk("nomatch_credit", 64'(credit), 64'd64);
        step(1'b0, '0, 1'b0, cpkt(ML, 4'd0, MP, 8'd255));
        chk("sat_credit", 64'(credit), 64'd128);
        // resend window in the middle of a burst
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, '0);
        chk("t6_credit", 64'(credit), 64'd122);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, '0);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(31, 0) == 0) begin
                leaf = 5'($urandom); port = 4'($urandom_range(15, 1));
            end
            case ($urandom_range(19, 0))
                0, 1:    bp = cpkt(ML, 4'd0, MP, 8'($urandom_range(40, 0)));
                2: begin
                    bp = 49'({$urandom, $urandom});
                    bp[42:39] = 4'($urandom_range(15, 1));
                end
                default: bp = '0;
            endcase
            w = $urandom;
            step($urandom_range(3, 0) != 0, w, $urandom_range(9, 0) == 0, bp);
        end
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
